// File: rtl/seq_mult_hs.sv
// Radix-2 shift-add sequential multiplier with valid/ready handshakes on both sides.
// Supports runtime signed (two's complement) or unsigned operands; one step per clock.
module seq_mult_hs #(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] product,
    output logic             busy
);

    localparam int CW = (WB > 1) ? $clog2(WB) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [WA-1:0]  mult_q, mult_d;
    logic [WA:0]    hi_q, hi_d;
    logic [WB-1:0]  lo_q, lo_d;
    logic           signedMode_q, signedMode_d;
    logic [CW-1:0]  count_q, count_d;

    logic [WA:0]    multExt;
    logic [WA:0]    stepSum;
    logic           lastStep;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mult_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            signedMode_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            mult_q       <= mult_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            signedMode_q <= signedMode_d;
            count_q      <= count_d;
        end
    end

    // The multiplier MSB carries negative weight in signed mode, so the last step subtracts.
    always_comb begin
        multExt  = signedMode_q ? {mult_q[WA-1], mult_q} : {1'b0, mult_q};
        lastStep = (count_q == CW'(WB - 1));
        if (!lo_q[0])
            stepSum = hi_q;
        else if (signedMode_q && lastStep)
            stepSum = hi_q - multExt;
        else
            stepSum = hi_q + multExt;
    end

    always_comb begin
        state_d      = state_q;
        mult_d       = mult_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        signedMode_d = signedMode_q;
        count_d      = count_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mult_d       = a;
                    hi_d         = '0;
                    lo_d         = b;
                    signedMode_d = signed_mode;
                    count_d      = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Unsigned mode keeps the sum's carry bit; signed mode replicates the sign.
                hi_d    = {signedMode_q & stepSum[WA], stepSum[WA:1]};
                lo_d    = {stepSum[0], lo_q[WB-1:1]};
                count_d = count_q + 1'b1;
                if (lastStep)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign product   = {hi_q[WA-1:0], lo_q};

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed and randomised self-checking bench for seq_mult_hs, covering an 8x8
// instance and a 6x3 instance that share clock and reset.
module tb_seq_mult_hs;

    logic        clock = 1'b0;
    logic        reset;

    logic        inValid, inReady, signedMode, outValid, outReady, busy;
    logic [7:0]  a, b;
    logic [15:0] product;

    logic        sInValid, sInReady, sSignedMode, sOutValid, sOutReady, sBusy;
    logic [5:0]  sA;
    logic [2:0]  sB;
    logic [8:0]  sProduct;

    int total = 0;
    int bad   = 0;
    int inHs  = 0;
    int outHs = 0;

    seq_mult_hs #(.WA(8), .WB(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .signed_mode(signedMode),
        .a(a), .b(b),
        .out_valid(outValid), .out_ready(outReady),
        .product(product), .busy(busy)
    );

    seq_mult_hs #(.WA(6), .WB(3)) dut63 (
        .clock(clock), .reset(reset),
        .in_valid(sInValid), .in_ready(sInReady), .signed_mode(sSignedMode),
        .a(sA), .b(sB),
        .out_valid(sOutValid), .out_ready(sOutReady),
        .product(sProduct), .busy(sBusy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset) begin
            if (inValid && inReady)   inHs  <= inHs + 1;
            if (outValid && outReady) outHs <= outHs + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached (got timeout, required completion)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full 8x8 transaction: offer, measure latency, optional stall in DONE, drain.
    task automatic applyStimulus(input logic sm, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [15:0] expP, input int stall, input string tag);
        int guard;
        int cyc;
        guard = 0;
        while (!inReady && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_inready"}, inReady, 1);
        signedMode = sm;
        a          = av;
        b          = bv;
        inValid    = 1'b1;
        tick();
        inValid = 1'b0;
        cyc = 0;
        while (!outValid && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, 8);
        repeat (stall) tick();
        checkOutput({tag, "_product"}, product, expP);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput({tag, "_drained"}, outValid, 0);
    endtask

    task automatic applyStimulusSmall(input logic sm, input logic [5:0] av, input logic [2:0] bv,
                                      input logic [8:0] expP, input string tag);
        int cyc;
        checkOutput({tag, "_inready"}, sInReady, 1);
        sSignedMode = sm;
        sA          = av;
        sB          = bv;
        sInValid    = 1'b1;
        tick();
        sInValid = 1'b0;
        cyc = 0;
        while (!sOutValid && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, 3);
        checkOutput({tag, "_product"}, sProduct, expP);
        sOutReady = 1'b1;
        tick();
        sOutReady = 1'b0;
    endtask

    initial begin
        int guard;
        int sawValid;
        int inStart;
        int outStart;
        logic        sm;
        logic [7:0]  av, bv;
        logic [15:0] expP;
        int          ra, rb, prod32;

        reset = 1'b1;
        inValid = 1'b0; signedMode = 1'b0; a = '0; b = '0; outReady = 1'b0;
        sInValid = 1'b0; sSignedMode = 1'b0; sA = '0; sB = '0; sOutReady = 1'b0;
        repeat (2) tick();
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_product", product, 16'h0000);
        checkOutput("rst_small_busy", sBusy, 0);
        reset = 1'b0;
        tick();
        checkOutput("idle_in_ready", inReady, 1);
        checkOutput("idle_small_in_ready", sInReady, 1);

        // Directed products in both modes and at the extreme operand values.
        applyStimulus(1'b0, 8'hFF, 8'hFF, 16'hFE01, 0, "u255x255");
        applyStimulus(1'b1, 8'h80, 8'h80, 16'h4000, 0, "s_m128xm128");
        applyStimulus(1'b1, 8'hFF, 8'h7F, 16'hFF81, 0, "s_m1x127");
        applyStimulus(1'b1, 8'h00, 8'hFB, 16'h0000, 0, "s_0xm5");
        applyStimulus(1'b0, 8'h80, 8'h80, 16'h4000, 0, "u128x128");
        applyStimulus(1'b1, 8'h7F, 8'h80, 16'hC080, 1, "s_127xm128");

        applyStimulusSmall(1'b1, 6'b100000, 3'b011, 9'h1A0, "small_s_m32x3");
        applyStimulusSmall(1'b0, 6'd63, 3'd7, 9'h1B9, "small_u63x7");
        applyStimulusSmall(1'b1, 6'b100000, 3'b100, 9'h080, "small_s_m32xm4");

        // Back-pressure: 100*3 held in DONE while inputs churn.
        signedMode = 1'b0; a = 8'd100; b = 8'd3; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        guard = 0;
        while (!outValid && guard < 40) begin
            tick();
            guard++;
        end
        checkOutput("bp_reached_done", outValid, 1);
        for (int i = 0; i < 10; i++) begin
            a          = 8'($urandom);
            b          = 8'($urandom);
            signedMode = 1'($urandom);
            inValid    = ~inValid;
            tick();
            checkOutput("bp_product", product, 16'h012C);
            checkOutput("bp_in_ready", inReady, 0);
            checkOutput("bp_out_valid", outValid, 1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("bp_released_valid", outValid, 0);
        checkOutput("bp_released_in_ready", inReady, 1);

        // Reset in the middle of an iteration discards the pending result.
        signedMode = 1'b0; a = 8'd200; b = 8'd200; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        repeat (3) tick();
        checkOutput("midrst_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", inReady, 0);
        checkOutput("midrst_product", product, 16'h0000);
        tick();
        reset = 1'b0;
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (outValid) sawValid++;
        end
        checkOutput("midrst_no_valid", sawValid, 0);
        applyStimulus(1'b0, 8'd17, 8'd3, 16'h0033, 0, "post_rst_17x3");

        // Random operands, modes and stalls against an integer reference.
        inStart  = inHs;
        outStart = outHs;
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom);
            av = 8'($urandom);
            bv = 8'($urandom);
            ra = sm ? int'($signed(av)) : int'({24'b0, av});
            rb = sm ? int'($signed(bv)) : int'({24'b0, bv});
            prod32 = ra * rb;
            expP   = prod32[15:0];
            applyStimulus(sm, av, bv, expP, int'($urandom_range(0, 3)), "rand");
        end
        tick();
        checkOutput("hs_count_in", inHs - inStart, 1000);
        checkOutput("hs_count_equal", inHs - inStart, outHs - outStart);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
